m_mem_arbiter: RTL and testbench
================================

Name: m_mem_arbiter

Overview:
Arbiter that shares one synchronous single-port memory between the instruction-fetch (IF) port and the data-access (MA) port of the pipelined RV32 core. It grants at most one access per cycle and routes the one-cycle-latency read data back to the requester that issued it. MA normally has priority, and a bounded-run counter guarantees that fetch always makes progress. It sits between the core's fetch/memory stages and a unified memory.

Parameters:
ADDR_W, 32, address width of both ports and the memory.
DATA_W, 32, data width.
MA_RUN_MAX, 4, maximum number of consecutive MA grants while IF is waiting. 0 means IF wins every conflict.

Ports:
w_clock  in  1  clock; all state changes on posedge.
w_reset  in  1  synchronous, active-high reset.
w_if_req  in  1  IF request; held with w_if_addr stable until granted.
w_if_addr  in  ADDR_W  IF byte address.
w_if_gnt  out  1  IF grant; access is issued to memory this cycle.
w_if_rvalid  out  1  IF read data valid.
w_if_rdata  out  DATA_W  IF read data.
w_if_stall  out  1  w_if_req & !w_if_gnt.
w_ma_req  in  1  MA request; held with w_ma_we/w_ma_addr/w_ma_wd stable until granted.
w_ma_we  in  1  1 = store, 0 = load.
w_ma_addr  in  ADDR_W  MA byte address.
w_ma_wd  in  DATA_W  MA store data.
w_ma_gnt  out  1  MA grant.
w_ma_rvalid  out  1  MA load data valid.
w_ma_rdata  out  DATA_W  MA load data.
w_mem_en  out  1  memory access enable.
w_mem_we  out  1  memory write enable.
w_mem_addr  out  ADDR_W  memory address.
w_mem_wd  out  DATA_W  memory write data.
w_mem_rd  in  DATA_W  memory read data, valid the cycle after an enabled read.
w_cnt_if_stall  out  32  IF stall-cycle counter (optional feature).
w_cnt_conflict  out  32  conflict-cycle counter (optional feature).

Behaviour:
- Grant logic is combinational from the requests and r_ma_run. Grants are mutually exclusive, never asserted without the matching request, and forced to 0 while w_reset = 1.
- Only one request: that port is granted.
- Both requests (conflict): MA is granted if r_ma_run < MA_RUN_MAX; otherwise IF is granted.
- r_ma_run (width clog2(MA_RUN_MAX+1), minimum 1) updates as follows:
  - +1 on an MA grant while w_if_req = 1, saturating at MA_RUN_MAX.
  - cleared to 0 on an IF grant, or in any cycle with w_if_req = 0.
- Memory issue:
  - w_mem_en = w_if_gnt | w_ma_gnt.
  - w_mem_we = w_ma_gnt & w_ma_we.
  - w_mem_addr / w_mem_wd are muxed from the granted port; all 0 when there is no grant. w_mem_wd is 0 on IF grants.
- Response tracking: registers r_rsp_if <= w_if_gnt and r_rsp_ma <= w_ma_gnt & !w_ma_we.
  - w_if_rvalid = r_rsp_if, w_ma_rvalid = r_rsp_ma.
  - Read data is w_mem_rd gated to the valid port; the non-valid port's rdata is 0.
  - Read latency is exactly 1 cycle after grant. Stores produce no rvalid.
- Back-to-back grants every cycle are allowed, and a new grant may issue in the same cycle as the previous rvalid.
- A requester deasserting its request before grant is legal; the request is simply dropped.
- Reset: r_ma_run, r_rsp_if, r_rsp_ma and the stat counters all go to 0, so every output is 0 the cycle after reset. A response pending when reset asserts is discarded and no rvalid appears.

Optional Feature:
ARB_STATS_EN:
- Defined:
  - w_cnt_if_stall increments on every cycle with w_if_stall = 1.
  - w_cnt_conflict increments on every cycle with both requests asserted.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both counter ports are driven constant 0 and no counter registers exist.

Test Plan:
- IF only: with mem[0x10] = 0xDEADBEEF, w_if_req = 1 and w_if_addr = 0x10 for one cycle -> w_if_gnt = 1 that cycle; next cycle w_if_rvalid = 1, w_if_rdata = 0xDEADBEEF, w_ma_rvalid = 0.
- MA store then load: store 0x12345678 to 0x20, then load 0x20 next cycle -> w_mem_we = 1 only in the store cycle; w_ma_rvalid = 1 with 0x12345678 one cycle after the load grant.
- Starvation bound: MA_RUN_MAX = 4, both requests held continuously -> grant pattern is MA, MA, MA, MA, IF, repeating; w_if_stall is high for exactly 4 of every 5 cycles.
- MA_RUN_MAX = 0, both requests held -> IF is granted every cycle and w_ma_gnt stays 0.
- Reset mid-access: assert w_reset in the cycle after an IF grant -> no w_if_rvalid appears, all outputs are 0, and r_ma_run is 0.
- ARB_STATS_EN defined: 10 conflict cycles with MA_RUN_MAX = 4 -> w_cnt_conflict = 10, w_cnt_if_stall = 8. Without the macro, both counters read 0.

Source files
------------

// File: rtl/m_mem_arbiter_if.sv
// Bundle of the IF port, MA port and unified-memory signals shared by m_mem_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface m_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              w_if_req;
    logic [ADDR_W-1:0] w_if_addr;
    logic              w_if_gnt;
    logic              w_if_rvalid;
    logic [DATA_W-1:0] w_if_rdata;
    logic              w_if_stall;

    logic              w_ma_req;
    logic              w_ma_we;
    logic [ADDR_W-1:0] w_ma_addr;
    logic [DATA_W-1:0] w_ma_wd;
    logic              w_ma_gnt;
    logic              w_ma_rvalid;
    logic [DATA_W-1:0] w_ma_rdata;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wd;
    logic [DATA_W-1:0] w_mem_rd;

    modport slave (
        input  w_if_req, w_if_addr,
        output w_if_gnt, w_if_rvalid, w_if_rdata, w_if_stall,
        input  w_ma_req, w_ma_we, w_ma_addr, w_ma_wd,
        output w_ma_gnt, w_ma_rvalid, w_ma_rdata,
        output w_mem_en, w_mem_we, w_mem_addr, w_mem_wd,
        input  w_mem_rd
    );

    modport master (
        output w_if_req, w_if_addr,
        input  w_if_gnt, w_if_rvalid, w_if_rdata, w_if_stall,
        output w_ma_req, w_ma_we, w_ma_addr, w_ma_wd,
        input  w_ma_gnt, w_ma_rvalid, w_ma_rdata,
        input  w_mem_en, w_mem_we, w_mem_addr, w_mem_wd,
        output w_mem_rd
    );
endinterface

// File: rtl/m_mem_arbiter.sv
// Single-port memory arbiter between IF and MA: MA has priority, bounded by MA_RUN_MAX.
// Optional macro ARB_STATS_EN adds IF-stall and conflict cycle counters.
module m_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MA_RUN_MAX = 4
) (
    input  logic                 w_clock,
    input  logic                 w_reset,
    m_mem_arbiter_if.slave       bus,
    output logic [31:0]          w_cnt_if_stall,
    output logic [31:0]          w_cnt_conflict
);
    localparam int RUN_W = (MA_RUN_MAX < 1) ? 1 : $clog2(MA_RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MA_RUN_MAX);

    logic [RUN_W-1:0] ma_run_r;
    logic             rsp_if_r;
    logic             rsp_ma_r;
    logic             if_gnt_s;
    logic             ma_gnt_s;
    logic             if_rvalid_s;
    logic             ma_rvalid_s;

    // Grant selection; ma_run_r never exceeds RUN_MAX, so "!=" is the "<" bound
    always_comb begin
        if_gnt_s = 1'b0;
        ma_gnt_s = 1'b0;
        case ({w_reset, bus.w_if_req, bus.w_ma_req})
            3'b001: ma_gnt_s = 1'b1;
            3'b010: if_gnt_s = 1'b1;
            3'b011: begin
                if (ma_run_r != RUN_MAX) begin
                    ma_gnt_s = 1'b1;
                end else begin
                    if_gnt_s = 1'b1;
                end
            end
            default: begin
                if_gnt_s = 1'b0;
                ma_gnt_s = 1'b0;
            end
        endcase
    end

    // Memory request mux from the granted port
    always_comb begin
        bus.w_mem_en   = if_gnt_s | ma_gnt_s;
        bus.w_mem_we   = ma_gnt_s & bus.w_ma_we;
        bus.w_mem_addr = {ADDR_W{1'b0}};
        bus.w_mem_wd   = {DATA_W{1'b0}};
        if (ma_gnt_s) begin
            bus.w_mem_addr = bus.w_ma_addr;
            bus.w_mem_wd   = bus.w_ma_wd;
        end else if (if_gnt_s) begin
            bus.w_mem_addr = bus.w_if_addr;
        end else begin
            bus.w_mem_addr = {ADDR_W{1'b0}};
        end
    end

    // Consecutive MA wins while IF waits; any cycle IF is not starved restarts the run
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            ma_run_r <= {RUN_W{1'b0}};
        end else if (ma_gnt_s && bus.w_if_req) begin
            if (ma_run_r != RUN_MAX) begin
                ma_run_r <= ma_run_r + RUN_W'(1);
            end else begin
                ma_run_r <= ma_run_r;
            end
        end else begin
            ma_run_r <= {RUN_W{1'b0}};
        end
    end

    // Remember who owns next cycle's read data; stores return nothing
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            rsp_if_r <= 1'b0;
            rsp_ma_r <= 1'b0;
        end else begin
            rsp_if_r <= if_gnt_s;
            rsp_ma_r <= ma_gnt_s & ~bus.w_ma_we;
        end
    end

    // A response still in flight when reset arrives is suppressed
    assign if_rvalid_s     = rsp_if_r & ~w_reset;
    assign ma_rvalid_s     = rsp_ma_r & ~w_reset;

    assign bus.w_if_gnt    = if_gnt_s;
    assign bus.w_ma_gnt    = ma_gnt_s;
    assign bus.w_if_stall  = bus.w_if_req & ~if_gnt_s;
    assign bus.w_if_rvalid = if_rvalid_s;
    assign bus.w_ma_rvalid = ma_rvalid_s;
    assign bus.w_if_rdata  = if_rvalid_s ? bus.w_mem_rd : {DATA_W{1'b0}};
    assign bus.w_ma_rdata  = ma_rvalid_s ? bus.w_mem_rd : {DATA_W{1'b0}};

`ifdef ARB_STATS_EN
    logic [31:0] cnt_if_stall_r;
    logic [31:0] cnt_conflict_r;

    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            cnt_if_stall_r <= 32'h0;
            cnt_conflict_r <= 32'h0;
        end else begin
            cnt_if_stall_r <= cnt_if_stall_r + {31'h0, bus.w_if_req & ~if_gnt_s};
            cnt_conflict_r <= cnt_conflict_r + {31'h0, bus.w_if_req & bus.w_ma_req};
        end
    end

    assign w_cnt_if_stall = cnt_if_stall_r;
    assign w_cnt_conflict = cnt_conflict_r;
`else
    assign w_cnt_if_stall = 32'h0;
    assign w_cnt_conflict = 32'h0;
`endif
endmodule

// File: tb/tb_m_mem_arbiter.sv
// Scoreboard bench for m_mem_arbiter: directed cases then randomized traffic vs a reference model.
module tb_m_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RUN_MAX = 4;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    logic        w_clock = 1'b0;
    logic        w_reset;
    logic        fill;
    logic        if_req, ma_req, ma_we;
    logic [31:0] if_addr, ma_addr, ma_wd;
    logic [31:0] cnt_stall, cnt_conf, cnt0_stall, cnt0_conf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int streak;
    int m_stall, m_conf;
    logic last_if_gnt, last_ma_gnt;
    logic [31:0] ref_mem [64];
    logic [31:0] env_mem [64];
    rsp_t if_q[$];
    rsp_t ma_q[$];
    rsp_t mon_e;

    m_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    m_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    m_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MA_RUN_MAX(RUN_MAX)) dut (
        .w_clock(w_clock), .w_reset(w_reset), .bus(bus),
        .w_cnt_if_stall(cnt_stall), .w_cnt_conflict(cnt_conf)
    );

    m_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MA_RUN_MAX(0)) dut0 (
        .w_clock(w_clock), .w_reset(w_reset), .bus(bus0),
        .w_cnt_if_stall(cnt0_stall), .w_cnt_conflict(cnt0_conf)
    );

    always #5 w_clock = ~w_clock;

    assign bus.w_if_req  = if_req;
    assign bus.w_if_addr = if_addr;
    assign bus.w_ma_req  = ma_req;
    assign bus.w_ma_we   = ma_we;
    assign bus.w_ma_addr = ma_addr;
    assign bus.w_ma_wd   = ma_wd;

    assign bus0.w_if_req  = 1'b1;
    assign bus0.w_if_addr = 32'h0000_0040;
    assign bus0.w_ma_req  = 1'b1;
    assign bus0.w_ma_we   = 1'b0;
    assign bus0.w_ma_addr = 32'h0000_0080;
    assign bus0.w_ma_wd   = 32'h0;
    assign bus0.w_mem_rd  = 32'h0;

    function automatic logic [31:0] mem_init(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge w_clock) cyc <= cyc + 1;

    // Unified single-port memory with one-cycle read latency
    always @(posedge w_clock) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= mem_init(i);
        end else if (bus.w_mem_en) begin
            if (bus.w_mem_we) env_mem[bus.w_mem_addr[7:2]] <= bus.w_mem_wd;
            else bus.w_mem_rd <= env_mem[bus.w_mem_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=rvalid-behaviour-wrong want=one-rvalid-per-read (cycle %0d)", name, cyc);
    endtask

    // Reference model step, evaluated at the falling edge for the current cycle's inputs
    task automatic check_and_model();
        logic e_if, e_ma;
        logic [31:0] e_addr, e_wd;
        if (w_reset) begin
            e_if = 1'b0;
            e_ma = 1'b0;
        end else begin
            e_ma = ma_req && (!if_req || streak < RUN_MAX);
            e_if = if_req && !e_ma;
        end
        e_addr = e_ma ? ma_addr : (e_if ? if_addr : 32'h0);
        e_wd   = e_ma ? ma_wd : 32'h0;
        chk("gnt", {bus.w_if_gnt, bus.w_ma_gnt, bus.w_if_stall}, {e_if, e_ma, if_req & !e_if});
        chk("mem_bus", {bus.w_mem_en, bus.w_mem_we, bus.w_mem_addr, bus.w_mem_wd},
            {e_if | e_ma, e_ma & ma_we, e_addr, e_wd});
        chk("gnt_run0", {bus0.w_if_gnt, bus0.w_ma_gnt}, w_reset ? 2'b00 : 2'b10);
`ifdef ARB_STATS_EN
        chk("cnt_stall", cnt_stall, m_stall);
        chk("cnt_conf", cnt_conf, m_conf);
        if (w_reset) begin
            m_stall = 0;
            m_conf  = 0;
        end else begin
            m_stall += (if_req && !e_if) ? 1 : 0;
            m_conf  += (if_req && ma_req) ? 1 : 0;
        end
`else
        chk("cnt_off", {cnt_stall, cnt_conf}, 64'h0);
`endif
        if (w_reset) streak = 0;
        else if (if_req && e_ma) streak = (streak + 1 > RUN_MAX) ? RUN_MAX : streak + 1;
        else streak = 0;
        if (e_ma && ma_we) ref_mem[ma_addr[7:2]] = ma_wd;
        if (e_ma && !ma_we) ma_q.push_back('{cyc: cyc, data: ref_mem[ma_addr[7:2]]});
        if (e_if) if_q.push_back('{cyc: cyc, data: ref_mem[if_addr[7:2]]});
        last_if_gnt = e_if;
        last_ma_gnt = e_ma;
    endtask

    // Response monitor: each rvalid must match the oldest outstanding read one cycle later
    always @(negedge w_clock) begin
        if (bus.w_if_rvalid) begin
            if (if_q.size() == 0) flag("if_rvalid_unexpected");
            else begin
                mon_e = if_q.pop_front();
                chk("if_latency", cyc - mon_e.cyc, 1);
                chk("if_rdata", bus.w_if_rdata, mon_e.data);
            end
        end else begin
            chk("if_rdata_idle", bus.w_if_rdata, 32'h0);
            if (if_q.size() > 0 && if_q[0].cyc < cyc) begin
                flag("if_rvalid_missing");
                void'(if_q.pop_front());
            end
        end
        if (bus.w_ma_rvalid) begin
            if (ma_q.size() == 0) flag("ma_rvalid_unexpected");
            else begin
                mon_e = ma_q.pop_front();
                chk("ma_latency", cyc - mon_e.cyc, 1);
                chk("ma_rdata", bus.w_ma_rdata, mon_e.data);
            end
        end else begin
            chk("ma_rdata_idle", bus.w_ma_rdata, 32'h0);
            if (ma_q.size() > 0 && ma_q[0].cyc < cyc) begin
                flag("ma_rvalid_missing");
                void'(ma_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge w_clock);
        check_and_model();
    endtask

    task automatic next();
        @(posedge w_clock);
        #1;
    endtask

    task automatic set_reset(input logic r);
        w_reset = r;
        if (r) begin
            if_q.delete();
            ma_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_init(i);
        streak = 0; m_stall = 0; m_conf = 0;
        last_if_gnt = 1'b0; last_ma_gnt = 1'b0;
        if_req = 1'b1; ma_req = 1'b1; ma_we = 1'b0;
        if_addr = 32'h0; ma_addr = 32'h4; ma_wd = 32'h0;
        fill = 1'b1;
        set_reset(1'b1);
        next();
        tick();
        next();
        fill = 1'b0;
        if_req = 1'b0; ma_req = 1'b0;
        tick();
        next();
        set_reset(1'b0);
        tick();
        chk("post_reset_quiet", {bus.w_if_rvalid, bus.w_ma_rvalid, bus.w_mem_en}, 3'b000);
        next();

        // IF-only fetch of the preloaded word
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("if_only_gnt", bus.w_if_gnt, 1'b1);
        next();
        if_req = 1'b0;
        tick();
        chk("if_only_rsp", {bus.w_if_rvalid, bus.w_ma_rvalid, bus.w_if_rdata}, {2'b10, 32'hDEAD_BEEF});
        next();

        // MA store then load of the same word
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 32'h20; ma_wd = 32'h1234_5678;
        tick();
        chk("store_we", bus.w_mem_we, 1'b1);
        next();
        ma_we = 1'b0; ma_wd = 32'h0;
        tick();
        chk("load_we", {bus.w_mem_we, bus.w_ma_rvalid}, 2'b00);
        next();
        ma_req = 1'b0;
        tick();
        chk("load_rsp", {bus.w_ma_rvalid, bus.w_ma_rdata}, {1'b1, 32'h1234_5678});
        next();

        // Starvation bound: ten conflict cycles straight out of reset
        set_reset(1'b1);
        tick();
        next();
        set_reset(1'b0);
        if_req = 1'b1; if_addr = 32'h8; ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h30;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("starve_pattern", {bus.w_if_gnt, bus.w_ma_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
            next();
        end
        if_req = 1'b0; ma_req = 1'b0;
        tick();
`ifdef ARB_STATS_EN
        chk("stats_10_conflicts", {cnt_conf, cnt_stall}, {32'd10, 32'd8});
`else
        chk("stats_disabled", {cnt_conf, cnt_stall}, 64'h0);
`endif
        next();

        // Reset asserted while an IF read is in flight
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        next();
        if_req = 1'b0;
        set_reset(1'b1);
        tick();
        chk("rst_mid_outputs", {bus.w_if_rvalid, bus.w_if_rdata, bus.w_if_gnt, bus.w_mem_en}, 35'h0);
        next();
        set_reset(1'b0);
        tick();
        chk("rst_mid_after", {bus.w_if_rvalid, bus.w_ma_rvalid}, 2'b00);
        next();

        // Randomized traffic; stalled requests mostly held, sometimes dropped
        for (int n = 0; n < 3000; n++) begin
            if (!(if_req && !last_if_gnt && $urandom_range(7, 0) != 0)) begin
                if_req  = ($urandom_range(9, 0) < 6);
                if_addr = {24'h0, 6'($urandom), 2'b00};
            end
            if (!(ma_req && !last_ma_gnt && $urandom_range(7, 0) != 0)) begin
                ma_req  = ($urandom_range(9, 0) < 6);
                ma_we   = 1'($urandom);
                ma_addr = {24'h0, 6'($urandom), 2'b00};
                ma_wd   = $urandom;
            end
            set_reset($urandom_range(199, 0) == 0);
            tick();
            next();
        end
        set_reset(1'b0);
        if_req = 1'b0; ma_req = 1'b0;
        tick();
        next();
        tick();
        next();
        chk("queues_drained", if_q.size() + ma_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
